// File: rtl/pred_tap_accum_pkg.sv
// Shared constants, types and helpers for the prediction tap accumulator.
package pred_tap_accum_pkg;

  localparam int unsigned PRED_SHIFT     = 6;
  localparam int unsigned PRED_ROUND     = 1 << (PRED_SHIFT - 1);
  localparam int unsigned PRED_BIT_DEPTH = 8;
  localparam int unsigned PRED_N_SAMPLES = 32;

  localparam int unsigned TAP_W  = 16;
  localparam int unsigned PAIR_W = 17;
  localparam int unsigned SUM_W  = 19;

  typedef logic signed [TAP_W-1:0]  tap_t;
  typedef logic signed [PAIR_W-1:0] pair_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  // Stage-1 register contents: pairwise tap sums plus the block-end marker.
  typedef struct packed {
    logic  valid;
    logic  last;
    pair_t s01;
    pair_t s23;
  } s1_t;

  function automatic int unsigned clip_max(input int unsigned bit_depth);
    return (1 << bit_depth) - 1;
  endfunction

  localparam int unsigned PRED_CLIP_MAX = clip_max(PRED_BIT_DEPTH);

  // Sign-extending pairwise add; cannot overflow in PAIR_W bits.
  function automatic pair_t pair_add(input tap_t a, input tap_t b);
    return pair_t'(a) + pair_t'(b);
  endfunction

endpackage

// File: rtl/pred_round_clip.sv
// Combinational round-to-nearest, arithmetic shift and clip of the final tap sum.
module pred_round_clip
  import pred_tap_accum_pkg::*;
#(
  parameter int unsigned SHIFT     = PRED_SHIFT,
  parameter int unsigned BIT_DEPTH = PRED_BIT_DEPTH
) (
  input  pair_t                s01,
  input  pair_t                s23,
  output logic [BIT_DEPTH-1:0] sample
);

  localparam sum_t ROUND    = sum_t'(2 ** (SHIFT - 1));
  localparam sum_t CLIP_MAX = sum_t'(clip_max(BIT_DEPTH));

  sum_t t_sum;
  sum_t t_shr;

  always_comb begin
    t_sum = sum_t'(s01) + sum_t'(s23) + ROUND;
    t_shr = t_sum >>> SHIFT;
    if (t_shr[SUM_W-1]) begin
      sample = '0;
    end else if (t_shr > CLIP_MAX) begin
      sample = CLIP_MAX[BIT_DEPTH-1:0];
    end else begin
      sample = t_shr[BIT_DEPTH-1:0];
    end
  end

endmodule

// File: rtl/pred_tap_accum.sv
// Two-stage tap-product accumulator producing clipped predicted samples with block-end marking.
module pred_tap_accum
  import pred_tap_accum_pkg::*;
#(
  parameter int unsigned N_SAMPLES = PRED_N_SAMPLES,
  parameter int unsigned BIT_DEPTH = PRED_BIT_DEPTH,
  parameter int unsigned SHIFT     = PRED_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [15:0]   p0,
  input  logic signed [15:0]   p1,
  input  logic signed [15:0]   p2,
  input  logic signed [15:0]   p3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_DEPTH-1:0] out_sample,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

  s1_t                  s1_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [BIT_DEPTH-1:0] out_sample_q;
  logic [BIT_DEPTH-1:0] rc_sample;
  logic                 advance;
  logic                 in_xfer;

  // Global stall: the whole pipe moves only when the output slot can drain.
  always_comb begin
    advance = !out_valid_q || out_ready;
    in_xfer = in_valid && advance;
  end

  assign in_ready   = advance;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_sample = out_sample_q;
  assign busy       = s1_q.valid || out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (in_xfer) begin
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (advance) begin
      s1_q.valid <= in_valid;
      if (in_valid) begin
        s1_q.last <= (idx_q == IDX_LAST);
        s1_q.s01  <= pair_add(p0, p1);
        s1_q.s23  <= pair_add(p2, p3);
      end
    end
  end

  pred_round_clip #(
    .SHIFT     (SHIFT),
    .BIT_DEPTH (BIT_DEPTH)
  ) u_round_clip (
    .s01    (s1_q.s01),
    .s23    (s1_q.s23),
    .sample (rc_sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_sample_q <= '0;
    end else if (advance) begin
      out_valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        out_last_q   <= s1_q.last;
        out_sample_q <= rc_sample;
      end
    end
  end

endmodule

// File: tb/tb_pred_tap_accum.sv
// Scoreboard bench for pred_tap_accum: expected samples queued at input transfer, checked at output.
module tb_pred_tap_accum;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic signed [15:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic              in_ready, out_valid, out_last, busy;
  logic [7:0]        out_sample;

  pred_tap_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .p0         (p0),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    bit l;
    int c;
  } item_t;

  item_t exp_q[$];
  item_t got_q[$];
  int    checks = 0;
  int    errors = 0;
  int    tb_idx = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back('{s: int'(out_sample), l: out_last, c: cyc});
  end

  function automatic int model(input int a, input int b, input int c, input int d);
    int t;
    t = (a + b + c + d + 32) >>> 6;
    if (t < 0) return 0;
    if (t > 255) return 255;
    return t;
  endfunction

  task automatic send(input int a, input int b, input int c, input int d, input int want = -1);
    bit accepted = 0;
    int w = (want >= 0) ? want : model(a, b, c, d);
    p0 = 16'(a); p1 = 16'(b); p2 = 16'(c); p3 = 16'(d);
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        exp_q.push_back('{s: w, l: (tb_idx == 31), c: cyc});
        tb_idx = (tb_idx + 1) % 32;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL send_accept in_ready never high within 100 cycles");
    end
  endtask

  task automatic drain(output bit ok);
    for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    ok = (got_q.size() == exp_q.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete(); got_q.delete(); tb_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_sample !== 8'd0) begin errors++; $display("FAIL reset_out_sample got %0d want 0", out_sample); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    item_t e, g;
    bit ok;
    out_ready = 1'b1;
    send(0, 6400, 0, 0, 100);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.s !== e.s || g.l !== e.l) begin errors++; $display("FAIL basic_sample got %0d/%0b want %0d/%0b", g.s, g.l, e.s, e.l); end
      checks++; if (g.c - e.c !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", g.c - e.c); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_rounding();
    int vec[10][5] = '{
      '{31, 0, 0, 0, 0}, '{32, 0, 0, 0, 1}, '{-33, 0, 0, 0, 0}, '{-765, 0, 0, 0, 0},
      '{0, 16320, 16320, 0, 255}, '{100, 200, -50, 3, 4}, '{16288, 0, 0, 0, 255},
      '{16287, 0, 0, 0, 254}, '{-32768, -32768, -32768, -32768, 0},
      '{32767, 32767, 32767, 32767, 255}};
    item_t e, g;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4]);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL round_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.s !== e.s || g.l !== e.l) begin errors++; $display("FAIL round_sample got %0d/%0b want %0d/%0b", g.s, g.l, e.s, e.l); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    item_t e, g;
    bit ok;
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++)
      send(int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 16000)) - 4000,
           int'($urandom_range(0, 9000)) - 3000, int'($urandom_range(0, 4000)) - 2000);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++;
      checks++; if (g.s !== e.s || g.l !== e.l) begin errors++; $display("FAIL b2b_sample #%0d got %0d/%0b want %0d/%0b", n, g.s, g.l, e.s, e.l); end
      checks++; if (g.c - e.c !== 2) begin errors++; $display("FAIL b2b_latency #%0d got %0d want 2", n, g.c - e.c); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    item_t e, g;
    bit ok;
    logic [7:0] held_s;
    logic held_l;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(int'($urandom_range(0, 20000)) - 5000, int'($urandom_range(0, 3000)), 0,
               int'($urandom_range(0, 1000)) - 500);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) begin held_s = out_sample; held_l = out_last; end
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b want 1", k, out_valid); end
          checks++; if (out_sample !== held_s || out_last !== held_l) begin errors++; $display("FAIL stall_hold cyc %0d got %0d/%b want %0d/%b", k, out_sample, out_last, held_s, held_l); end
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b want 0", k, in_ready); end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.s !== e.s || g.l !== e.l) begin errors++; $display("FAIL stall_sample got %0d/%0b want %0d/%0b", g.s, g.l, e.s, e.l); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midflight();
    item_t e, g;
    bit ok;
    int n = 0;
    out_ready = 1'b1;
    send(1000, 2000, 0, 0);
    send(3000, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    exp_q.delete(); got_q.delete(); tb_idx = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) send(64 * i, i, -i, 7);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++;
      checks++; if (g.s !== e.s || g.l !== e.l) begin errors++; $display("FAIL midrst_sample #%0d got %0d/%0b want %0d/%0b", n, g.s, g.l, e.s, e.l); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_tap_accum.md
PRED_TAP_ACCUM -- requirements
Module: pred_tap_accum

Interface
REQ-001 Parameter N_SAMPLES, default 32, samples per prediction block row.
REQ-002 Parameter BIT_DEPTH, default 8, output sample width.
REQ-003 Parameter SHIFT, default 6, filter normalisation shift; rounding offset = 2^(SHIFT-1).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  tap-product set present.
REQ-007 in_ready  output  1  block accepts the set this cycle.
REQ-008 p0, p1, p2, p3  input  16 each, signed  tap products from the constant-multiplier stage.
REQ-009 out_valid  output  1  predicted sample present.
REQ-010 out_ready  input  1  downstream accepts sample.
REQ-011 out_sample  output  BIT_DEPTH, unsigned  clipped predicted sample.
REQ-012 out_last  output  1  marks the sample at index N_SAMPLES-1 of a block.
REQ-013 busy  output  1  any pipeline stage holds valid data.

Function
REQ-014 Transfer on either side occurs only when valid and ready are both high in the same cycle.
REQ-015 Two-stage pipeline; S1 registers s01 = p0+p1 and s23 = p2+p3 (17-bit signed); S2 registers the final sample.
REQ-016 S2 computes t = s01 + s23 + 2^(SHIFT-1) in 19-bit signed, then arithmetic shift right by SHIFT (floor).
REQ-017 Clip: t<0 -> 0; t > 2^BIT_DEPTH-1 -> 2^BIT_DEPTH-1; otherwise t.
REQ-018 Latency: an input accepted in cycle n is presented on out_* in cycle n+2 when no stall occurs.
REQ-019 advance = !out_valid || out_ready; in_ready = advance; S1 and S2 load only when advance is high (global stall).
REQ-020 Throughput one sample per cycle while out_ready is held high.
REQ-021 When stalled, out_sample, out_last and out_valid hold stable until accepted.
REQ-022 Bubbles: S1/S2 valid bits propagate in_valid through the pipeline; a bubble never produces out_valid.
REQ-023 Sample counter idx (log2 N_SAMPLES bits) increments on each input transfer, wraps N_SAMPLES-1 -> 0.
REQ-024 out_last is carried through the pipeline with its sample: high iff that sample was accepted at idx = N_SAMPLES-1.
REQ-025 Simultaneous input transfer and output transfer in one cycle is legal and loses no data.
REQ-026 in_ready does not depend combinationally on in_valid.

Reset
REQ-027 rst_n low clears S1/S2 valid bits, idx, out_valid, out_last, out_sample, busy to 0 immediately, independent of clk.
REQ-028 Reset mid-block discards in-flight samples; the first input after reset is index 0.
REQ-029 in_ready is high in the first cycle after reset release.

Structure
REQ-030 Shared package holds PRED_SHIFT, PRED_ROUND, BIT_DEPTH, N_SAMPLES defaults and the clip-max constant.
REQ-031 One sub-module, pred_round_clip (combinational round, shift, clip), instantiated in S2.
REQ-032 No multipliers; adds, shifts and compares only.

Verification
REQ-033 p={0,6400,0,0}, out_ready=1 -> out_sample=100 exactly 2 cycles after transfer.
REQ-034 Rounding: p={31,0,0,0} -> 0; p={32,0,0,0} -> 1; p={-33,0,0,0} -> 0 (clip of -1).
REQ-035 Clip: p={-765,0,0,0} -> 0; p={0,16320,16320,0} -> 255.
REQ-036 Stream 64 sets, out_ready=1 -> 64 samples in order, out_last on the 32nd and 64th.
REQ-037 out_ready low for 5 cycles mid-stream -> in_ready low once pipeline full, output held stable, no loss or duplication.
REQ-038 Assert rst_n low with 2 samples in flight -> out_valid=0 at once; next block's first sample index 0, out_last on its 32nd.
